// File: rtl/vga_vram_arbiter.sv
// Display/game arbiter for one single-port synchronous VRAM. The display has absolute priority.
// Define VGA_VRAM_POSTED_WR_EN to add a 1-entry posted write buffer for game writes.
module vga_vram_arbiter #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              gm_req,
    input  logic              gm_we,
    input  logic [ADDR_W-1:0] gm_addr,
    input  logic [DATA_W-1:0] gm_wdata,
    output logic              gm_ready,
    output logic [DATA_W-1:0] gm_rdata,
    output logic              gm_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  gm_wait_cnt
);

    // Handshake: a game transfer is taken in every cycle where gm_req & gm_ready; gm_ready
    // may depend on this cycle's requests. The display is never stalled and needs no ready.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              sel_any;
    logic              sel_we;
    logic              sel_disp;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [MEM_LAT:0]  tag_v;
    logic [MEM_LAT:0]  tag_disp;

    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_wdata;

`ifdef VGA_VRAM_POSTED_WR_EN
    logic buf_drain;
    logic buf_load;

    assign buf_drain = buf_full & ~disp_req;
    // Reads wait for an empty buffer so a buffered write can never be overtaken.
    assign gm_ready  = gm_we ? (~buf_full | buf_drain) : (~disp_req & ~buf_full);
    assign buf_load  = gm_req & gm_we & gm_ready & (disp_req | buf_full);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_full  <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
        end else if (buf_load) begin
            buf_full  <= 1'b1;
            buf_addr  <= gm_addr;
            buf_wdata <= gm_wdata;
        end else if (buf_drain) begin
            buf_full  <= 1'b0;
        end
    end
`else
    assign buf_full  = 1'b0;
    assign buf_addr  = '0;
    assign buf_wdata = '0;
    assign gm_ready  = ~disp_req;
`endif

    always_comb begin
        sel_any   = 1'b0;
        sel_we    = 1'b0;
        sel_disp  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (disp_req) begin
            sel_any  = 1'b1;
            sel_disp = 1'b1;
            sel_addr = disp_addr;
        end else if (buf_full) begin
            sel_any   = 1'b1;
            sel_we    = 1'b1;
            sel_addr  = buf_addr;
            sel_wdata = buf_wdata;
        end else if (gm_req && gm_ready) begin
            sel_any   = 1'b1;
            sel_we    = gm_we;
            sel_addr  = gm_addr;
            sel_wdata = gm_wdata;
        end
    end

    // Tag stage MEM_LAT lines up with the cycle mem_rdata is valid for that access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            tag_v       <= '0;
            tag_disp    <= '0;
            disp_rvalid <= 1'b0;
            gm_rvalid   <= 1'b0;
            disp_rdata  <= '0;
            gm_rdata    <= '0;
        end else begin
            mem_en   <= sel_any;
            mem_we   <= sel_we;
            if (sel_any) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            tag_v    <= {tag_v[MEM_LAT-1:0], sel_any & ~sel_we};
            tag_disp <= {tag_disp[MEM_LAT-1:0], sel_disp};
            disp_rvalid <= tag_v[MEM_LAT] & tag_disp[MEM_LAT];
            gm_rvalid   <= tag_v[MEM_LAT] & ~tag_disp[MEM_LAT];
            if (tag_v[MEM_LAT] && tag_disp[MEM_LAT]) disp_rdata <= mem_rdata;
            if (tag_v[MEM_LAT] && !tag_disp[MEM_LAT]) gm_rdata <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gm_wait_cnt <= '0;
        end else if (clr_stats) begin
            gm_wait_cnt <= '0;
        end else if (gm_req && !gm_ready && gm_wait_cnt != CNT_MAX) begin
            gm_wait_cnt <= gm_wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Bench for vga_vram_arbiter: two instances (read latency 1 and 3) share one stimulus stream
// and are checked every cycle against a transaction-level model of the arbiter.
`timescale 1ns/1ps
module tb_vga_vram_arbiter;

    localparam int AW    = 17;
    localparam int DW    = 8;
    localparam int CW    = 16;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int MSZ   = 512;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic gm_req = 1'b0;
    logic gm_we = 1'b0;
    logic [AW-1:0] gm_addr = '0;
    logic [DW-1:0] gm_wdata = '0;
    logic clr_stats = 1'b0;

    logic [DW-1:0] disp_rdata_a, gm_rdata_a, mem_wdata_a, mem_rdata_a;
    logic disp_rvalid_a, gm_ready_a, gm_rvalid_a, mem_en_a, mem_we_a;
    logic [AW-1:0] mem_addr_a;
    logic [CW-1:0] gm_wait_cnt_a;
    logic [DW-1:0] disp_rdata_b, gm_rdata_b, mem_wdata_b, mem_rdata_b;
    logic disp_rvalid_b, gm_ready_b, gm_rvalid_b, mem_en_b, mem_we_b;
    logic [AW-1:0] mem_addr_b;
    logic [CW-1:0] gm_wait_cnt_b;

    always #5 clk = ~clk;

    vga_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_A), .CNT_W(CW)) u_dut_a (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata_a), .disp_rvalid(disp_rvalid_a),
        .gm_req(gm_req), .gm_we(gm_we), .gm_addr(gm_addr), .gm_wdata(gm_wdata),
        .gm_ready(gm_ready_a), .gm_rdata(gm_rdata_a), .gm_rvalid(gm_rvalid_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_rdata(mem_rdata_a), .clr_stats(clr_stats), .gm_wait_cnt(gm_wait_cnt_a)
    );

    vga_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_B), .CNT_W(CW)) u_dut_b (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata_b), .disp_rvalid(disp_rvalid_b),
        .gm_req(gm_req), .gm_we(gm_we), .gm_addr(gm_addr), .gm_wdata(gm_wdata),
        .gm_ready(gm_ready_b), .gm_rdata(gm_rdata_b), .gm_rvalid(gm_rvalid_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .clr_stats(clr_stats), .gm_wait_cnt(gm_wait_cnt_b)
    );

    // VRAM stand-ins with 1 and 3 cycles of read latency
    logic [DW-1:0] vram_a [0:MSZ-1];
    logic [DW-1:0] vram_b [0:MSZ-1];
    logic [DW-1:0] rd_a, rd_b1, rd_b2, rd_b3;

    always @(posedge clk) begin
        if (mem_en_a && mem_we_a) vram_a[mem_addr_a[8:0]] <= mem_wdata_a;
        rd_a <= vram_a[mem_addr_a[8:0]];
        if (mem_en_b && mem_we_b) vram_b[mem_addr_b[8:0]] <= mem_wdata_b;
        rd_b1 <= vram_b[mem_addr_b[8:0]];
        rd_b2 <= rd_b1;
        rd_b3 <= rd_b2;
    end
    assign mem_rdata_a = rd_a;
    assign mem_rdata_b = rd_b3;

    // Behavioural model: a log of accepted reads plus the expected VRAM contents
    typedef struct {
        int            acc;
        logic          disp;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           rd_log[$];
    logic [DW-1:0] shadow [0:MSZ-1];
    int            cyc = 0;
    int            idx_a = 0;
    int            idx_b = 0;
    logic [DW-1:0] last_dd_a = '0, last_gd_a = '0, last_dd_b = '0, last_gd_b = '0;
    logic          exp_en = 1'b0, exp_we = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;
    int unsigned   exp_cnt = 0;
    logic          pend = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic [DW-1:0] pend_data = '0;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_ready();
`ifdef VGA_VRAM_POSTED_WR_EN
        return gm_we ? (!pend || !disp_req) : (!disp_req && !pend);
`else
        return !disp_req;
`endif
    endfunction

    task automatic check_ret(input string tag, input int lat,
                             input logic dv, input logic [DW-1:0] dd,
                             input logic gv, input logic [DW-1:0] gd,
                             inout int idx, inout logic [DW-1:0] ld, inout logic [DW-1:0] lg);
        logic ev_d, ev_g;
        ev_d = 1'b0;
        ev_g = 1'b0;
        if (idx < rd_log.size() && rd_log[idx].acc + lat + 2 == cyc) begin
            if (rd_log[idx].disp) begin
                ev_d = 1'b1;
                ld = rd_log[idx].data;
            end else begin
                ev_g = 1'b1;
                lg = rd_log[idx].data;
            end
            idx++;
        end
        chk({tag, " disp_rvalid"}, dv, ev_d);
        chk({tag, " gm_rvalid"}, gv, ev_g);
        chk({tag, " disp_rdata"}, dd, ld);
        chk({tag, " gm_rdata"}, gd, lg);
    endtask

    task automatic issue_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_en = 1'b1;
        exp_we = 1'b1;
        exp_addr = a;
        exp_wdata = d;
        shadow[a[8:0]] = d;
    endtask

    // Compare process: outputs are checked mid-cycle, then the model consumes this cycle's inputs
    initial begin : compare
        logic rdy, acc, pend_before;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                idx_a = rd_log.size();
                idx_b = idx_a;
                pend = 1'b0;
                exp_en = 1'b0;
                exp_we = 1'b0;
                exp_cnt = 0;
                last_dd_a = '0; last_gd_a = '0; last_dd_b = '0; last_gd_b = '0;
                chk("rst mem_en", mem_en_a, 0);
                chk("rst mem_we", mem_we_a, 0);
                chk("rst mem_addr", mem_addr_a, 0);
                chk("rst mem_wdata", mem_wdata_a, 0);
                chk("rst disp_rvalid", disp_rvalid_a, 0);
                chk("rst gm_rvalid", gm_rvalid_a, 0);
                chk("rst disp_rdata", disp_rdata_a, 0);
                chk("rst gm_rdata", gm_rdata_a, 0);
                chk("rst gm_wait_cnt", gm_wait_cnt_a, 0);
                chk("rst b disp_rvalid", disp_rvalid_b, 0);
                chk("rst b gm_rvalid", gm_rvalid_b, 0);
            end else begin
                chk("mem_en", mem_en_a, exp_en);
                chk("b mem_en", mem_en_b, exp_en);
                if (exp_en) begin
                    chk("mem_we", mem_we_a, exp_we);
                    chk("mem_addr", mem_addr_a, exp_addr);
                    if (exp_we) chk("mem_wdata", mem_wdata_a, exp_wdata);
                end
                check_ret("a", LAT_A, disp_rvalid_a, disp_rdata_a, gm_rvalid_a, gm_rdata_a,
                          idx_a, last_dd_a, last_gd_a);
                check_ret("b", LAT_B, disp_rvalid_b, disp_rdata_b, gm_rvalid_b, gm_rdata_b,
                          idx_b, last_dd_b, last_gd_b);
                chk("gm_wait_cnt", gm_wait_cnt_a, exp_cnt);
                chk("b gm_wait_cnt", gm_wait_cnt_b, exp_cnt);
                rdy = model_ready();
                chk("gm_ready", gm_ready_a, rdy);
                chk("b gm_ready", gm_ready_b, rdy);
                acc = gm_req && rdy;
                if (clr_stats) exp_cnt = 0;
                else if (gm_req && !rdy && exp_cnt < CMAX) exp_cnt++;
                pend_before = pend;
                exp_en = 1'b0;
                exp_we = 1'b0;
                if (disp_req) begin
                    exp_en = 1'b1;
                    exp_addr = disp_addr;
                    rd_log.push_back('{cyc, 1'b1, shadow[disp_addr[8:0]]});
                end else if (pend_before) begin
                    issue_write(pend_addr, pend_data);
                end else if (acc) begin
                    if (gm_we) issue_write(gm_addr, gm_wdata);
                    else begin
                        exp_en = 1'b1;
                        exp_addr = gm_addr;
                        rd_log.push_back('{cyc, 1'b0, shadow[gm_addr[8:0]]});
                    end
                end
                if (acc && gm_we && (disp_req || pend_before)) begin
                    pend = 1'b1;
                    pend_addr = gm_addr;
                    pend_data = gm_wdata;
                end else if (pend_before && !disp_req) begin
                    pend = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_req = 1'b0;
        gm_req = 1'b0;
        gm_we = 1'b0;
        clr_stats = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : driver
        int pd;
        idle();
        repeat (3) tick();
        chk("lit reset mem_en", mem_en_a, 0);
        chk("lit reset gm_wait_cnt", gm_wait_cnt_a, 0);
        reset = 1'b1;

        // Fill the whole test window through the game port
        for (int a = 0; a < MSZ; a++) begin
            gm_req = 1'b1; gm_we = 1'b1; gm_addr = AW'(a); gm_wdata = DW'((a * 7 + 3) & 8'hFF);
            tick();
        end

        // Write 0x5A to 0x100, then read it back
        gm_req = 1'b1; gm_we = 1'b1; gm_addr = 17'h00100; gm_wdata = 8'h5A;
        tick();
        chk("lit wr mem_we", mem_we_a, 1);
        chk("lit wr mem_addr", mem_addr_a, 17'h00100);
        chk("lit wr mem_wdata", mem_wdata_a, 8'h5A);
        gm_we = 1'b0;
        tick();
        idle();
        tick();
        chk("lit rd gm_rvalid early", gm_rvalid_a, 0);
        tick();
        chk("lit rd gm_rvalid", gm_rvalid_a, 1);
        chk("lit rd gm_rdata", gm_rdata_a, 8'h5A);

        // Ten stalled cycles, then the game read goes through
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        for (int i = 0; i < 10; i++) begin
            disp_req = 1'b1; disp_addr = AW'(i); gm_req = 1'b1; gm_we = 1'b0; gm_addr = 17'h00020;
            #1;
            chk("lit stall gm_ready", gm_ready_a, 0);
            tick();
        end
        disp_req = 1'b0;
        #1;
        chk("lit stall gm_wait_cnt", gm_wait_cnt_a, 10);
        chk("lit stall release gm_ready", gm_ready_a, 1);
        tick();
        idle();
        repeat (6) tick();

        // Display burst 0..7 with game reads filling the idle cycles
        for (int k = 0; k < 14; k++) begin
            disp_req = (k < 8); disp_addr = AW'(k); gm_req = 1'b1; gm_we = 1'b0; gm_addr = AW'(8'h40 + k);
            #1;
            chk("lit burst disp_rvalid", disp_rvalid_a, (k >= 3 && k <= 10));
            chk("lit burst lat3 disp_rvalid", disp_rvalid_b, (k >= 5 && k <= 12));
            tick();
        end
        idle();
        repeat (6) tick();

        // Clear wins over a stall in the same cycle
        disp_req = 1'b1; gm_req = 1'b1; gm_we = 1'b0;
        tick();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("lit clr priority", gm_wait_cnt_a, 0);
        idle();
        repeat (6) tick();

        // Reset with reads in flight
        for (int i = 0; i < 3; i++) begin
            disp_req = 1'b1; disp_addr = AW'(16 + i);
            tick();
        end
        reset = 1'b0;
        idle();
        #1;
        chk("lit midrst mem_en", mem_en_a, 0);
        chk("lit midrst disp_rvalid", disp_rvalid_a, 0);
        repeat (2) tick();
        chk("lit midrst mem_addr", mem_addr_a, 0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("lit post-rst disp_rvalid", disp_rvalid_a, 0);
            chk("lit post-rst lat3 disp_rvalid", disp_rvalid_b, 0);
        end

`ifdef VGA_VRAM_POSTED_WR_EN
        // Posted write while the display owns the RAM
        disp_req = 1'b1; disp_addr = 17'h00003; gm_req = 1'b1; gm_we = 1'b1; gm_addr = 17'h001A0; gm_wdata = 8'hC3;
        #1;
        chk("lit pw write ready", gm_ready_a, 1);
        tick();
        gm_we = 1'b0;
        #1;
        chk("lit pw read stalled", gm_ready_a, 0);
        tick();
        disp_req = 1'b0;
        #1;
        chk("lit pw read behind buffer", gm_ready_a, 0);
        tick();
        chk("lit pw drain mem_we", mem_we_a, 1);
        chk("lit pw drain mem_addr", mem_addr_a, 17'h001A0);
        chk("lit pw drain mem_wdata", mem_wdata_a, 8'hC3);
        chk("lit pw read ready", gm_ready_a, 1);
        tick();
        idle();
        repeat (6) tick();
`endif

        // Random traffic with changing display load
        pd = 45;
        for (int n = 0; n < 2000; n++) begin
            if (n % 100 == 0) pd = $urandom_range(0, 3) * 33;
            disp_req  = ($urandom_range(0, 99) < pd);
            disp_addr = AW'($urandom_range(0, MSZ - 1));
            gm_req    = ($urandom_range(0, 99) < 70);
            gm_we     = $urandom_range(0, 1) == 1;
            gm_addr   = AW'($urandom_range(0, MSZ - 1));
            gm_wdata  = DW'($urandom_range(0, 255));
            clr_stats = ($urandom_range(0, 63) == 0);
            tick();
        end
        idle();
        repeat (8) tick();

        // Saturation: stall long enough to pin the counter at its maximum
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        disp_req = 1'b1; disp_addr = 17'h00005; gm_req = 1'b1; gm_we = 1'b0;
        repeat (CMAX + 5) tick();
        chk("lit sat gm_wait_cnt", gm_wait_cnt_a, 16'hFFFF);
        tick();
        chk("lit sat hold gm_wait_cnt", gm_wait_cnt_a, 16'hFFFF);
        idle();
        repeat (8) tick();

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
